// File: rtl/char_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// char_ram_arbiter_if
//   Bundles the two buses around the character RAM arbiter:
//   - the terminal writer req/ack port (wr_*)
//   - the single-port character RAM port (ram_*)
//   slave  : arbiter side (consumes writer requests, drives the RAM)
//   master : environment side (writer logic plus the RAM itself)
// Parameters
//   ADDR_W  RAM / writer address width
// ----------------------------------------------------------------------------
interface char_ram_arbiter_if #(
  parameter int ADDR_W = 12
) ();
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ack;
  logic              wr_oob;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, ram_rdata,
    output wr_ack, wr_oob, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, ram_rdata,
    input  wr_ack, wr_oob, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/char_ram_arbiter.sv
// ----------------------------------------------------------------------------
// char_ram_arbiter
//   Shares the single-port character RAM of the pseudo-terminal between the
//   display scan-out, a clear-screen sweep and a req/ack terminal writer.
//   The character code of each 8-pixel cell is fetched two pixels ahead of
//   its first pixel so the glyph renderer never waits.
// Ports
//   clk        system clock
//   reset      synchronous reset, active-low
//   strobe     pixel enable from the 640x480 timing generator (1 clk wide)
//   xPos/yPos  current pixel column (0..799) / line (0..524)
//   clear_req  1-clk pulse, starts a clear sweep when not busy
//   busy       clear sweep in progress
//   char_code  character for the cell being displayed
//   char_valid 1-clk pulse when char_code updates
//   bus        writer port and RAM port (char_ram_arbiter_if.slave)
// ----------------------------------------------------------------------------
module char_ram_arbiter #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 30,
  parameter int         CELL_W = 8,
  parameter int         CELL_H = 16,
  parameter int         ADDR_W = 12,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                strobe,
  input  logic [9:0]          xPos,
  input  logic [9:0]          yPos,
  input  logic                clear_req,
  output logic                busy,
  output logic [7:0]          char_code,
  output logic                char_valid,
  char_ram_arbiter_if.slave   bus
);

  localparam int CW_SH     = $clog2(CELL_W);
  localparam int CH_SH     = $clog2(CELL_H);
  localparam int NCELL     = COLS * ROWS;
  localparam int ACT_LINES = ROWS * CELL_H;

  // Operation occupying the RAM during the current cycle. CAPTURE marks the
  // idle cycle in which fetched data is returning from the RAM.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;

  // row * COLS built only from shifted copies of row, one per set bit of COLS.
  function automatic logic [ADDR_W-1:0] row_times_cols(input logic [9:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 31; b++) begin
      if (((COLS >> b) & 1) == 1) acc = acc + (ADDR_W'(row) << b);
    end
    return acc;
  endfunction

  logic [2:0]        r_state;
  logic              r_vld_p1;
  logic              r_en;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_wr_ack;
  logic              r_wr_oob;
  logic              r_busy;
  logic [ADDR_W:0]   r_cnt;
  logic [7:0]        r_char_code;
  logic              r_char_valid;

  logic [9:0]        w_xcell;
  logic              w_col_trig;
  logic              w_eol_trig;
  logic [9:0]        w_line;
  logic [9:0]        w_row;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_trig;
  logic              w_start_clr;
  logic              w_clr_go;
  logic              w_wr_go;
  logic              w_wr_oob;

  // Trigger decode: two pixels before a cell boundary (cols 1..COLS-1 of
  // the current line) or at xPos 798 for col 0 of the following line.
  always_comb begin
    w_xcell    = xPos >> CW_SH;
    w_col_trig = strobe && ((xPos & 10'(CELL_W - 1)) == 10'(CELL_W - 2)) &&
                 (w_xcell < 10'(COLS - 1));
    w_eol_trig = strobe && (xPos == 10'd798);
    if (w_eol_trig) begin
      w_line = (yPos == 10'd524) ? 10'd0 : yPos + 10'd1;
      w_col  = '0;
    end else begin
      w_line = yPos;
      w_col  = ADDR_W'(w_xcell + 10'd1);
    end
    w_row        = w_line >> CH_SH;
    w_fetch_addr = row_times_cols(w_row) + w_col;
    w_trig       = (w_col_trig || w_eol_trig) && (w_line < 10'(ACT_LINES));
  end

  // Slot arbitration for the next cycle. The slot is decided on the same edge
  // the trigger is sampled and fetch always wins, so a trigger that lands
  // during a write/clear cycle is served in the very next cycle.
  always_comb begin
    w_start_clr = clear_req && !r_busy;
    w_clr_go    = r_busy && (r_cnt != (ADDR_W + 1)'(NCELL)) && !w_trig;
    // r_wr_ack blocks a second ack while the writer is still lowering wr_req.
    w_wr_go     = bus.wr_req && !r_busy && !w_start_clr && !w_trig && !r_wr_ack;
    w_wr_oob    = ({1'b0, bus.wr_addr} >= (ADDR_W + 1)'(NCELL));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_vld_p1     <= 1'b0;
      r_en         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr_ack     <= 1'b0;
      r_wr_oob     <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_char_code  <= '0;
      r_char_valid <= 1'b0;
    end else begin
      r_en         <= 1'b0;
      r_we         <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_wr_oob     <= 1'b0;
      r_char_valid <= 1'b0;
      r_state      <= (r_state == S_FETCH) ? S_CAPTURE : S_IDLE;

      // p0 -> p1: fetch cycle done, RAM output valid during the next cycle
      r_vld_p1 <= (r_state == S_FETCH);

      // p1 -> p2: capture the returned character
      if (r_vld_p1) begin
        r_char_code  <= bus.ram_rdata;
        r_char_valid <= 1'b1;
      end

      if (w_trig) begin
        r_state <= S_FETCH;
        r_en    <= 1'b1;
        r_addr  <= w_fetch_addr;
      end else if (w_clr_go) begin
        r_state <= S_CLEAR;
        r_en    <= 1'b1;
        r_we    <= 1'b1;
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_wdata <= BLANK;
        r_cnt   <= r_cnt + 1'b1;
      end else if (w_wr_go) begin
        r_wr_ack <= 1'b1;
        if (w_wr_oob) begin
          r_wr_oob <= 1'b1;
        end else begin
          r_state <= S_WRITE;
          r_en    <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= bus.wr_addr;
          r_wdata <= bus.wr_data;
        end
      end

      // The counter reaching NCELL means the last blank was written in the
      // cycle just ended, so the sweep is over.
      if (w_start_clr) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_busy && (r_cnt == (ADDR_W + 1)'(NCELL))) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.ram_en    = r_en;
  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.wr_ack    = r_wr_ack;
  assign bus.wr_oob    = r_wr_oob;
  assign busy          = r_busy;
  assign char_code     = r_char_code;
  assign char_valid    = r_char_valid;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_char_ram_arbiter
//   Directed bench for char_ram_arbiter with a behavioural single-port RAM
//   (read data registered one clock after ram_en & !ram_we).
// ----------------------------------------------------------------------------
module tb_char_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       strobe;
  logic [9:0] xPos;
  logic [9:0] yPos;
  logic       clear_req;
  logic       busy;
  logic [7:0] char_code;
  logic       char_valid;

  char_ram_arbiter_if #(.ADDR_W(12)) bus ();

  char_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .strobe     (strobe),
    .xPos       (xPos),
    .yPos       (yPos),
    .clear_req  (clear_req),
    .busy       (busy),
    .char_code  (char_code),
    .char_valid (char_valid),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int clr_n     = 0;
  int clr_exp   = 0;
  int clr_bad   = 0;
  int fetch_n   = 0;
  int cv_n      = 0;
  int ack_busy  = 0;

  always @(negedge clk) begin
    if (bus.ram_en && bus.ram_we && bus.ram_wdata == 8'h20) begin
      if (int'(bus.ram_addr) != clr_exp) clr_bad++;
      clr_exp++;
      clr_n++;
    end
    if (bus.ram_en && !bus.ram_we) fetch_n++;
    if (char_valid) cv_n++;
    if (bus.wr_ack && busy) ack_busy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counters();
    clr_n = 0; clr_exp = 0; clr_bad = 0; fetch_n = 0; cv_n = 0; ack_busy = 0;
  endtask

  // One pixel period: strobe for one clk then three idle clks.
  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     output logic en_o, output logic [11:0] addr_o,
                     output logic cv2, output logic [7:0] code2);
    xPos = x; yPos = y; strobe = 1'b1;
    step();
    en_o   = bus.ram_en && !bus.ram_we;
    addr_o = bus.ram_addr;
    strobe = 1'b0;
    step();
    step();
    cv2   = char_valid;
    code2 = char_code;
    step();
  endtask

  function automatic bit line0_trig(input int x);
    return ((x % 8) == 6 && x < 632) || x == 798;
  endfunction

  logic       en_o, cv2;
  logic [11:0] addr_o;
  logic [7:0]  code2;
  int          x, cyc, exp_trig, bad;
  bit          done;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = (i < 80) ? 8'(8'h41 + i) : 8'h00;
    bus.ram_rdata = 8'h00;
    reset = 1'b0; strobe = 1'b0; xPos = '0; yPos = '0; clear_req = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    step(); step();
    reset = 1'b1;
    step();

    // Load a character, then reset mid-frame with all requesters active.
    pix(10'd798, 10'd524, en_o, addr_o, cv2, code2);
    check("pre_reset_code", code2, 8'h41);
    reset = 1'b0; strobe = 1'b1; xPos = 10'd6; yPos = 10'd0; clear_req = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 12'd5; bus.wr_data = 8'h11;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_char_code", char_code, 8'h00);
      check("rst_wr_ack", bus.wr_ack, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ram_en", bus.ram_en, 1'b0);
      check("rst_char_valid", char_valid, 1'b0);
    end
    reset = 1'b1; strobe = 1'b0; clear_req = 1'b0; bus.wr_req = 1'b0;
    step();

    // Scan-out across the end of line 524 into line 0.
    pix(10'd798, 10'd524, en_o, addr_o, cv2, code2);
    check("f0_en", en_o, 1'b1);
    check("f0_addr", addr_o, 12'd0);
    check("f0_valid", cv2, 1'b1);
    check("f0_code", code2, 8'h41);
    pix(10'd799, 10'd524, en_o, addr_o, cv2, code2);
    check("x799_en", en_o, 1'b0);
    check("x799_valid", cv2, 1'b0);
    pix(10'd0, 10'd0, en_o, addr_o, cv2, code2);
    check("x0_code", code2, 8'h41);
    pix(10'd5, 10'd0, en_o, addr_o, cv2, code2);
    check("x5_en", en_o, 1'b0);
    check("x5_code", code2, 8'h41);
    pix(10'd6, 10'd0, en_o, addr_o, cv2, code2);
    check("x6_en", en_o, 1'b1);
    check("x6_addr", addr_o, 12'd1);
    check("x6_valid", cv2, 1'b1);
    check("x6_code", code2, 8'h42);
    pix(10'd8, 10'd0, en_o, addr_o, cv2, code2);
    check("x8_code", code2, 8'h42);
    check("x8_valid", cv2, 1'b0);
    pix(10'd14, 10'd0, en_o, addr_o, cv2, code2);
    check("x14_addr", addr_o, 12'd2);
    check("x14_code", code2, 8'h43);
    pix(10'd798, 10'd479, en_o, addr_o, cv2, code2);
    check("y480_no_fetch", en_o, 1'b0);
    check("y480_no_valid", cv2, 1'b0);
    pix(10'd630, 10'd17, en_o, addr_o, cv2, code2);
    check("col79_en", en_o, 1'b1);
    check("col79_addr", addr_o, 12'd159);
    pix(10'd638, 10'd0, en_o, addr_o, cv2, code2);
    check("x638_no_fetch", en_o, 1'b0);
    pix(10'd798, 10'd15, en_o, addr_o, cv2, code2);
    check("row1_addr", addr_o, 12'd80);

    // Writer request on the same edge as a fetch trigger.
    bus.wr_req = 1'b1; bus.wr_addr = 12'd85; bus.wr_data = 8'h5A;
    strobe = 1'b1; xPos = 10'd6; yPos = 10'd0;
    step();
    strobe = 1'b0;
    check("col_fetch_first_we", {bus.ram_en, bus.ram_we}, 2'b10);
    check("col_fetch_addr", bus.ram_addr, 12'd1);
    check("col_no_ack_yet", bus.wr_ack, 1'b0);
    step();
    check("col_ack", bus.wr_ack, 1'b1);
    check("col_wr_we", {bus.ram_en, bus.ram_we}, 2'b11);
    check("col_wr_addr", bus.ram_addr, 12'd85);
    check("col_wr_data", bus.ram_wdata, 8'h5A);
    check("col_no_oob", bus.wr_oob, 1'b0);
    bus.wr_req = 1'b0;
    step();
    check("col_ack_drop", bus.wr_ack, 1'b0);
    check("col_mem85", mem[85], 8'h5A);
    check("col_code", char_code, 8'h42);

    // Out-of-range writer address.
    bus.wr_req = 1'b1; bus.wr_addr = 12'd2400; bus.wr_data = 8'h77;
    step();
    check("oob_ack", bus.wr_ack, 1'b1);
    check("oob_flag", bus.wr_oob, 1'b1);
    check("oob_ram_en", bus.ram_en, 1'b0);
    bus.wr_req = 1'b0;
    step();
    check("oob_ack_drop", {bus.wr_ack, bus.wr_oob}, 2'b00);
    check("oob_no_write", mem[2400], 8'h00);

    // Clear sweep during active video with a writer held throughout.
    clr_counters();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clr_busy", busy, 1'b1);
    bus.wr_req = 1'b1; bus.wr_addr = 12'd10; bus.wr_data = 8'h99;
    x = 0; cyc = 0; exp_trig = 0; done = 1'b0;
    while (!done && cyc < 20000) begin
      if (cyc % 4 == 0) begin
        strobe = 1'b1; xPos = 10'(x); yPos = 10'd0;
        if (line0_trig(x)) exp_trig++;
        x++;
      end else begin
        strobe = 1'b0;
      end
      step();
      cyc++;
      if (!busy) done = 1'b1;
    end
    strobe = 1'b0;
    check("clr_done", done, 1'b1);
    check("clr_count", clr_n, 2400);
    check("clr_order", clr_bad, 0);
    check("clr_ack_busy", ack_busy, 0);
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      step();
      if (bus.wr_ack) done = 1'b1;
    end
    bus.wr_req = 1'b0;
    check("clr_wr_acked_after", done, 1'b1);
    step(); step(); step();
    check("clr_fetches", fetch_n, exp_trig);
    check("clr_valids", cv_n, exp_trig);
    bad = 0;
    for (int i = 0; i < 2400; i++) if (i != 10 && mem[i] != 8'h20) bad++;
    check("clr_mem_blank", bad, 0);
    check("clr_mem10", mem[10], 8'h99);

    // Reset in the middle of a sweep, then restart from address 0.
    clr_counters();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    cyc = 0;
    while (clr_n < 1000 && cyc < 5000) begin
      step();
      cyc++;
    end
    check("mid_reach_1000", (clr_n >= 1000), 1'b1);
    reset = 1'b0;
    step();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ram_en", bus.ram_en, 1'b0);
    reset = 1'b1;
    clr_counters();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("restart_busy", busy, 1'b1);
    cyc = 0;
    while (busy && cyc < 5000) begin
      step();
      cyc++;
    end
    check("restart_done", busy, 1'b0);
    check("restart_count", clr_n, 2400);
    check("restart_order", clr_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
